// File: rtl/mmp_iddmm_mul_arb.sv
// Round-robin front end for one shared pipelined DW x DW multiplier: grants one
// requester per cycle, registers its operands, and routes the product back by tag.
module mmp_iddmm_mul_arb #(
  parameter int N_REQ       = 4,
  parameter int DW          = 128,
  parameter int MUL_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  input  logic [2*DW-1:0]     mul_c,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [2*DW-1:0]     rsp_data,
  output logic                busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a pair moves on a rising edge where req_valid[i] & req_ready[i];
  // a requester keeps valid/a/b stable until then. Responses have no ready.
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     win_id;
  logic [IDW-1:0]     next_ptr;
  logic [IDW-1:0]     idx_w;
  logic               any_grant;
  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;
  logic [MUL_LATENCY:0] tag_vld;
  logic [IDW-1:0]     tag_id [0:MUL_LATENCY];
  int                 idx;

  // First valid requester at or after rr_ptr, wrapping; nothing is granted in reset.
  always_comb begin
    req_ready = '0;
    win_id    = '0;
    any_grant = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IDW'(idx);
      if (!any_grant && rst_n && req_valid[idx_w]) begin
        any_grant        = 1'b1;
        win_id           = idx_w;
        req_ready[idx_w] = 1'b1;
      end
    end
  end

  // One-hot OR mux: operands fall to zero when nothing is granted.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a = sel_a | req_a[i*DW +: DW];
        sel_b = sel_b | req_b[i*DW +: DW];
      end
    end
  end

  assign next_ptr = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      rr_ptr  <= '0;
      tag_vld <= '0;
      for (int k = 0; k <= MUL_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      mul_a      <= sel_a;
      mul_b      <= sel_b;
      tag_vld[0] <= any_grant;
      tag_id[0]  <= win_id;
      if (any_grant) rr_ptr <= next_ptr;
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = tag_vld[MUL_LATENCY] && (tag_id[MUL_LATENCY] == IDW'(i));
    end
  end

  assign rsp_data = mul_c;
  assign busy     = |tag_vld;

endmodule

// File: tb/tb_mmp_iddmm_mul_arb.sv
// Bench for mmp_iddmm_mul_arb: directed and random traffic against a queue-based
// model of grant order, product values and return timing; plus a zero-latency build.
module tb_mmp_iddmm_mul_arb;

  localparam int N_REQ = 4;
  localparam int DW    = 128;
  localparam int LAT   = 4;
  localparam int PW    = 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (LATENCY 4) ----------------
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a = '0;
  logic [N_REQ*DW-1:0] req_b = '0;
  logic [DW-1:0]       mul_a, mul_b;
  logic [PW-1:0]       mul_c;
  logic [N_REQ-1:0]    rsp_valid;
  logic [PW-1:0]       rsp_data;
  logic                busy;

  mmp_iddmm_mul_arb #(.N_REQ(N_REQ), .DW(DW), .MUL_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the shared multiplier: LAT register stages after the operand register.
  logic [PW-1:0] mul_pipe [0:LAT-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) mul_pipe[k] <= '0;
    end else begin
      mul_pipe[0] <= PW'(mul_a) * PW'(mul_b);
      for (int k = 1; k < LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
  end
  assign mul_c = mul_pipe[LAT-1];

  // ---------------- zero-latency DUT ----------------
  logic [N_REQ-1:0]    req_valid0 = '0;
  logic [N_REQ-1:0]    req_ready0;
  logic [N_REQ*DW-1:0] req_a0 = '0;
  logic [N_REQ*DW-1:0] req_b0 = '0;
  logic [DW-1:0]       mul_a0, mul_b0;
  logic [PW-1:0]       mul_c0;
  logic [N_REQ-1:0]    rsp_valid0;
  logic [PW-1:0]       rsp_data0;
  logic                busy0;

  mmp_iddmm_mul_arb #(.N_REQ(N_REQ), .DW(DW), .MUL_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_c(mul_c0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0)
  );
  assign mul_c0 = PW'(mul_a0) * PW'(mul_b0);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a pointer as an integer, and the queue of products still owed.
  int               model_rr = 0;
  int               exp_win  = 0;
  logic [N_REQ-1:0] exp_grant = '0;
  logic [DW-1:0]    exp_mul_a = '0;
  logic [DW-1:0]    exp_mul_b = '0;
  logic [PW-1:0]    exp_q[$];
  int               exp_id_q[$];
  int               exp_due_q[$];
  int               cyc = 0;

  function automatic void model_grant();
    exp_grant = '0;
    exp_win   = 0;
    if (rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (model_rr + k) % N_REQ;
        if (req_valid[i]) begin
          exp_grant[i] = 1'b1;
          exp_win      = i;
          break;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_id_q.delete();
    exp_due_q.delete();
    model_rr  = 0;
    exp_mul_a = '0;
    exp_mul_b = '0;
    exp_grant = '0;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    logic [N_REQ-1:0] exp_rsp;
    logic [PW-1:0]    exp_data;
    logic [DW-1:0]    wa, wb;
    #1;
    model_grant();
    check("req_ready", PW'(req_ready), PW'(exp_grant));
    check("busy", PW'(busy), PW'(exp_due_q.size() > 0));
    check("mul_a", PW'(mul_a), PW'(exp_mul_a));
    check("mul_b", PW'(mul_b), PW'(exp_mul_b));
    exp_rsp  = '0;
    exp_data = '0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      exp_rsp  = N_REQ'(1) << exp_id_q[0];
      exp_data = exp_q[0];
      void'(exp_q.pop_front());
      void'(exp_id_q.pop_front());
      void'(exp_due_q.pop_front());
    end
    check("rsp_valid", PW'(rsp_valid), PW'(exp_rsp));
    check("rsp_data", rsp_data, exp_data);
    @(posedge clk);
    cyc++;
    if (exp_grant != '0) begin
      wa = req_a[exp_win*DW +: DW];
      wb = req_b[exp_win*DW +: DW];
      exp_q.push_back(PW'(wa) * PW'(wb));
      exp_id_q.push_back(exp_win);
      exp_due_q.push_back(cyc + LAT);
      exp_mul_a = wa;
      exp_mul_b = wb;
      model_rr  = (exp_win + 1) % N_REQ;
    end else begin
      exp_mul_a = '0;
      exp_mul_b = '0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i]      = 1'b1;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       rnd_op = '1;
      1:       rnd_op = DW'($urandom_range(0, 15));
      default: rnd_op = {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  // Release whichever requesters were accepted at the last edge.
  task automatic drop_accepted();
    req_valid = req_valid & ~exp_grant;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] ones;
    ones = '1;

    // Reset with random inputs: nothing granted, nothing in flight.
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      req_valid = N_REQ'($urandom_range(0, 15));
      req_a     = {8{$urandom, $urandom}};
      req_b     = {8{$urandom, $urandom}};
      cycle();
    end
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rst_n     = 1'b1;
    idle(2);

    // Single op from requester 2.
    set_req(2, 128'd3, 128'd5);
    cycle();
    drop_accepted();
    idle(LAT + 3);

    // All four requesters hold valid with maximal operands.
    for (int i = 0; i < N_REQ; i++) set_req(i, ones, ones);
    for (int t = 0; t < 8; t++) cycle();
    idle(LAT + 3);

    // Pointer skip: move the pointer to 1, then offer only 0 and 3.
    set_req(0, 128'd6, 128'd7);
    cycle();
    drop_accepted();
    set_req(0, 128'd11, 128'd13);
    set_req(3, 128'd17, 128'd19);
    cycle();
    drop_accepted();
    cycle();
    drop_accepted();
    idle(LAT + 3);

    // Back-to-back from requester 1.
    for (int t = 1; t <= 3; t++) begin
      set_req(1, DW'(t), DW'(t));
      cycle();
    end
    idle(LAT + 3);

    // Random traffic; valid stays up until accepted.
    for (int t = 0; t < 400; t++) begin
      drop_accepted();
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) set_req(i, rnd_op(), rnd_op());
      end
      cycle();
    end
    for (int t = 0; t < 4 * N_REQ && req_valid != '0; t++) begin
      drop_accepted();
      if (req_valid != '0) cycle();
    end
    check("drain", PW'(req_valid & ~exp_grant), '0);
    idle(LAT + 3);

    // Zero-latency build: product follows acceptance by one cycle.
    req_valid0         = 4'b0010;
    req_a0[DW +: DW]   = 128'd7;
    req_b0[DW +: DW]   = 128'd9;
    #1;
    check("l0_req_ready", PW'(req_ready0), PW'(4'b0010));
    check("l0_busy_before", PW'(busy0), '0);
    @(posedge clk);
    #1;
    check("l0_rsp_valid", PW'(rsp_valid0), PW'(4'b0010));
    check("l0_rsp_data", rsp_data0, PW'(63));
    check("l0_busy", PW'(busy0), PW'(1));
    @(negedge clk);
    req_valid0 = '0;
    @(posedge clk);
    #1;
    check("l0_rsp_after", PW'(rsp_valid0), '0);
    check("l0_data_after", rsp_data0, '0);
    check("l0_busy_after", PW'(busy0), '0);
    @(negedge clk);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) set_req(i, rnd_op(), rnd_op());
    for (int t = 0; t < 3; t++) begin
      cycle();
      drop_accepted();
    end
    idle(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_busy", PW'(busy), '0);
    check("rst_rsp_valid", PW'(rsp_valid), '0);
    check("rst_mul_a", PW'(mul_a), '0);
    cycle();
    cycle();
    rst_n = 1'b1;
    idle(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
